// File: rtl/pipe_serialize_if.sv
// pipe_serialize_if: have/want handshake bundle for the wide-to-narrow
// serializer.
//   i_in    wide input word (OUT_WIDTH*RATIO bits)
//   i_have  upstream word valid
//   o_want  serializer can take a word this cycle
//   o_out   current narrow beat (OUT_WIDTH bits)
//   o_have  o_out is valid
//   o_last  current beat is the final beat of its word
//   i_want  downstream accepts the beat this cycle
// The slave modport is the serializer. The master modport is the
// producer/consumer side that surrounds it.
interface pipe_serialize_if #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4
) ();
    logic [OUT_WIDTH*RATIO-1:0] i_in;
    logic                       i_have;
    logic                       o_want;
    logic [OUT_WIDTH-1:0]       o_out;
    logic                       o_have;
    logic                       o_last;
    logic                       i_want;

    modport slave (
        input  i_in, i_have, i_want,
        output o_want, o_out, o_have, o_last
    );

    modport master (
        output i_in, i_have, i_want,
        input  o_want, o_out, o_have, o_last
    );
endinterface

// File: rtl/pipe_serialize.sv
// pipe_serialize: transmit-side width converter. It accepts one wide word of
// RATIO beats and emits the beats one per downstream transfer. When the last
// beat leaves, the block accepts the next word in the same cycle, so
// back-to-back words stream with no bubble.
//   i_clk    clock (rising edge)
//   i_reset  asynchronous, active-high reset
//   bus      pipe_serialize_if.slave (i_in/i_have/o_want upstream,
//            o_out/o_have/o_last/i_want downstream)
// Parameters:
//   OUT_WIDTH  beat width in bits (>= 1)
//   RATIO      beats per word (>= 2)
//   LSB_FIRST  1: beat 0 is the low slice; 0: beat 0 is the high slice
module pipe_serialize #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    pipe_serialize_if.slave  bus
);
    localparam int CW = $clog2(RATIO);
    localparam int WW = OUT_WIDTH * RATIO;

    logic                               loaded;
    logic [WW-1:0]                      word_q;
    logic [CW-1:0]                      cnt;
    logic [RATIO-1:0][OUT_WIDTH-1:0]    beats;
    logic                               last_beat;
    logic                               dt;
    logic                               ut;

    // Reorder the word into transmit order so that the beat counter always
    // indexes beat 0 first, whatever LSB_FIRST is.
    for (genvar g = 0; g < RATIO; g++) begin : g_beat
        if (LSB_FIRST) begin : g_lsb
            assign beats[g] = word_q[g*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_msb
            assign beats[g] = word_q[(RATIO-1-g)*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    assign last_beat   = loaded && (cnt == CW'(RATIO-1));
    assign dt          = loaded && bus.i_want;
    // The combinational path from i_want to o_want lets a new word land on
    // the same edge that the last beat leaves.
    assign bus.o_want  = !loaded || (last_beat && bus.i_want);
    assign ut          = bus.i_have && bus.o_want;
    assign bus.o_have  = loaded;
    assign bus.o_last  = last_beat;

    // Explicit mux. RATIO need not be a power of two, so cnt may be able to
    // encode values that are not valid beat indices.
    always_comb begin
        bus.o_out = '0;
        for (int i = 0; i < RATIO; i++)
            if (cnt == CW'(i)) bus.o_out = beats[i];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            loaded <= 1'b0;
            cnt    <= '0;
            word_q <= '0;
        end else if (ut) begin
            word_q <= bus.i_in;
            loaded <= 1'b1;
            cnt    <= '0;
        end else if (dt) begin
            if (last_beat) begin
                loaded <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt    <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipe_serialize.sv
// tb_pipe_serialize: directed checks on two 8x4 instances (LSB-first and
// MSB-first). It also runs a randomized 5x3 instance against a beat-queue
// reference model.
module tb_pipe_serialize;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_serialize_if #(.OUT_WIDTH(8), .RATIO(4)) b0 ();
    pipe_serialize_if #(.OUT_WIDTH(8), .RATIO(4)) b1 ();
    pipe_serialize_if #(.OUT_WIDTH(5), .RATIO(3)) b2 ();

    pipe_serialize #(.OUT_WIDTH(8), .RATIO(4), .LSB_FIRST(1'b1)) u0 (
        .i_clk(clk), .i_reset(rst), .bus(b0.slave));
    pipe_serialize #(.OUT_WIDTH(8), .RATIO(4), .LSB_FIRST(1'b0)) u1 (
        .i_clk(clk), .i_reset(rst), .bus(b1.slave));
    pipe_serialize #(.OUT_WIDTH(5), .RATIO(3), .LSB_FIRST(1'b1)) u2 (
        .i_clk(clk), .i_reset(rst), .bus(b2.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the visible state of instance 0.
    task automatic chk0(input string tag, input logic hv, input logic [7:0] d,
                        input logic ls, input logic wn);
        chk({tag, ".have"}, 32'(b0.o_have), 32'(hv));
        if (hv) chk({tag, ".out"}, 32'(b0.o_out), 32'(d));
        chk({tag, ".last"}, 32'(b0.o_last), 32'(ls));
        chk({tag, ".want"}, 32'(b0.o_want), 32'(wn));
    endtask

    logic [7:0] exp8 [8];
    logic [4:0] q [$];
    logic [14:0] w15;
    logic e_have, e_last, e_want;

    initial begin
        b0.i_in = '0; b0.i_have = 1'b0; b0.i_want = 1'b0;
        b1.i_in = '0; b1.i_have = 1'b0; b1.i_want = 1'b0;
        b2.i_in = '0; b2.i_have = 1'b0; b2.i_want = 1'b0;
        #12;
        chk("rst.have", 32'(b0.o_have), 32'd0);
        chk("rst.last", 32'(b0.o_last), 32'd0);
        chk("rst.out",  32'(b0.o_out),  32'd0);
        chk("rst.want", 32'(b0.o_want), 32'd1);
        tick();
        rst = 1'b0;

        // Basic case on u0, and the same word MSB-first on u1.
        b0.i_in = 32'hDDCCBBAA; b0.i_have = 1'b1; b0.i_want = 1'b1;
        b1.i_in = 32'hDDCCBBAA; b1.i_have = 1'b1; b1.i_want = 1'b1;
        #1;
        chk0("basic.idle", 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        b0.i_have = 1'b0; b1.i_have = 1'b0;
        exp8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0, 8'h0, 8'h0, 8'h0};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk0($sformatf("basic.b%0d", k), 1'b1, exp8[k], k == 3, k == 3);
            chk($sformatf("msb.b%0d", k), 32'(b1.o_out), 32'(exp8[3-k]));
            chk($sformatf("msb.last%0d", k), 32'(b1.o_last), 32'(k == 3));
            tick();
        end
        #1;
        chk0("basic.done", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("msb.done", 32'(b1.o_have), 32'd0);

        // Back-to-back words with no gap between them.
        b0.i_in = 32'h44332211; b0.i_have = 1'b1;
        tick();
        b0.i_in = 32'h88776655;
        exp8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int k = 0; k < 8; k++) begin
            if (k == 4) b0.i_have = 1'b0;
            #1;
            chk0($sformatf("b2b.b%0d", k), 1'b1, exp8[k], k == 3 || k == 7, k == 3 || k == 7);
            tick();
        end
        #1;
        chk0("b2b.done", 1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure while BB is shown. The upstream word changes during
        // the stall and must be ignored.
        b0.i_in = 32'hDDCCBBAA; b0.i_have = 1'b1;
        tick();
        b0.i_have = 1'b0;
        #1;
        chk0("bp.aa", 1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        b0.i_want = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b0.i_in = 32'h11111111 * (k + 1); b0.i_have = 1'b1;
            #1;
            chk0($sformatf("bp.stall%0d", k), 1'b1, 8'hBB, 1'b0, 1'b0);
            tick();
        end
        b0.i_have = 1'b0; b0.i_want = 1'b1;
        #1;
        chk0("bp.bb", 1'b1, 8'hBB, 1'b0, 1'b0);
        tick(); #1;
        chk0("bp.cc", 1'b1, 8'hCC, 1'b0, 1'b0);
        tick(); #1;
        chk0("bp.dd", 1'b1, 8'hDD, 1'b1, 1'b1);
        tick(); #1;
        chk0("bp.done", 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset in the middle of a word, after beat BB has transferred.
        b0.i_in = 32'hDDCCBBAA; b0.i_have = 1'b1;
        tick();
        b0.i_have = 1'b0;
        tick(); tick();
        #1;
        chk0("mid.cc", 1'b1, 8'hCC, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk0("mid.rst", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("mid.rst.out", 32'(b0.o_out), 32'd0);
        tick();
        rst = 1'b0;
        b0.i_in = 32'h0403020A; b0.i_have = 1'b1;
        #1;
        chk0("mid.idle", 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        b0.i_have = 1'b0;
        exp8 = '{8'h0A, 8'h02, 8'h03, 8'h04, 8'h0, 8'h0, 8'h0, 8'h0};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk0($sformatf("mid.b%0d", k), 1'b1, exp8[k], k == 3, k == 3);
            tick();
        end
        #1;
        chk0("mid.done", 1'b0, 8'h00, 1'b0, 1'b1);

        // Random stress on u2. The model holds the beats still owed
        // downstream; the head of the queue is the beat on display.
        for (int c = 0; c < 10000; c++) begin
            b2.i_have = 1'($urandom_range(0, 1));
            b2.i_want = ($urandom_range(0, 3) != 0);
            b2.i_in   = 15'($urandom);
            #1;
            e_have = (q.size() != 0);
            e_last = (q.size() == 1);
            e_want = (q.size() == 0) || (q.size() == 1 && b2.i_want);
            chk("rnd.have", 32'(b2.o_have), 32'(e_have));
            chk("rnd.last", 32'(b2.o_last), 32'(e_last));
            chk("rnd.want", 32'(b2.o_want), 32'(e_want));
            if (e_have) chk("rnd.out", 32'(b2.o_out), 32'(q[0]));
            if (e_have && b2.i_want) void'(q.pop_front());
            if (b2.i_have && e_want) begin
                w15 = b2.i_in;
                for (int j = 0; j < 3; j++) q.push_back(w15[j*5 +: 5]);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_serialize.md
Name: pipe_serialize

Overview:
- Transmit-side width converter for the have/want streaming handshake.
- Accepts one wide word of RATIO narrow beats on the input side and emits RATIO narrow beats, one per downstream transfer, on the output side.
- Placed between a wide producer (e.g. an interlock stage) and a narrow consumer.
- Sustains one beat per cycle with no bubble between consecutive words.

Parameters:
- OUT_WIDTH, 8, width of one output beat in bits; must be >= 1.
- RATIO, 4, number of beats per input word; must be >= 2.
- LSB_FIRST, 1: 1 = beat 0 is i_in[OUT_WIDTH-1:0]; 0 = beat 0 is the most significant slice.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_in  in  OUT_WIDTH*RATIO  wide input word.
- i_have  in  1  upstream word valid.
- o_want  out  1  block can accept a word this cycle.
- o_out  out  OUT_WIDTH  current beat.
- o_have  out  1  o_out is valid.
- o_last  out  1  current beat is beat RATIO-1 of its word.
- i_want  in  1  downstream accepts the beat this cycle.

Behaviour:
- Transfers:
  - Upstream transfer (UT) when i_have && o_want at a rising edge.
  - Downstream transfer (DT) when o_have && i_want at a rising edge.
- State:
  - loaded (1 bit): word register holds an unsent word.
  - word register (OUT_WIDTH*RATIO bits).
  - beat counter cnt, width clog2(RATIO), range 0..RATIO-1.
- Reset (async, any time, including mid-word):
  - loaded=0, cnt=0, word register=0.
  - Outputs during and after reset: o_have=0, o_last=0, o_out=0, o_want=1.
  - A partially sent word is discarded; no beat from it appears after reset.
- Outputs (combinational from state, plus i_want for o_want):
  - o_have = loaded.
  - o_out = slice cnt of the word register, ordered per LSB_FIRST.
  - o_last = loaded && (cnt == RATIO-1).
  - o_want = !loaded || (o_last && i_want). The i_want -> o_want combinational path is required for zero-bubble throughput.
- Per-edge update:
  - DT with cnt < RATIO-1: cnt <= cnt+1.
  - DT with cnt == RATIO-1 and no UT: loaded <= 0, cnt <= 0.
  - UT (loaded==0, or last beat leaving in the same cycle): word register <= i_in, loaded <= 1, cnt <= 0.
  - Simultaneous last-beat DT and UT: the new word takes effect and beat 0 of it is presented the next cycle. No idle cycle.
  - Neither: hold all state.
- Latency: a word accepted at edge k presents beat 0 during cycle k+1.
- Throughput: back-to-back words with i_want=1 produce exactly one beat per cycle.
- Stall rule: while o_have=1 and i_want=0, o_out, o_have and o_last hold stable. The word register never changes while loaded and not on the last-beat DT.
- i_in and i_have are ignored when o_want=0; they may change freely.
- i_want while o_have=0 has no effect.
- Beat order within a word is never reordered, skipped or duplicated.
- No X on any output after reset is released.

Test Plan:
- Basic (OUT_WIDTH=8, RATIO=4, LSB_FIRST=1): single UT of 32'hDDCCBBAA, i_want=1 -> beats AA, BB, CC, DD on 4 consecutive cycles starting 1 cycle after UT; o_last=1 only with DD; then o_have=0.
- Back-to-back: i_have=1 with 32'h44332211 then 32'h88776655, i_want=1 -> 8 consecutive beats 11..88 with no gap; o_want=1 exactly on the cycle beat 44 transfers.
- Backpressure:
  - i_want=0 for 3 cycles while beat BB is shown -> o_out stays BB, o_have=1, o_want=0.
  - Upstream word change during the stall -> ignored.
  - Sequence resumes CC, DD.
- MSB-first (LSB_FIRST=0): 32'hDDCCBBAA -> beats DD, CC, BB, AA.
- Reset mid-word: assert i_reset after beat BB transfers -> outputs go to o_have=0, o_out=0, o_want=1 immediately; after release, new word 32'h0403020A -> beats 0A, 02, 03, 04 with no residue.
- Random stress (RATIO=3, OUT_WIDTH=5):
  - Random i_have and i_want for 10k cycles.
  - Scoreboard confirms every accepted word appears as exactly RATIO ordered beats, o_last on each third beat.
  - Confirms no output change during stalls.
